umstr_reg_if_axil: RTL and testbench



---
 rtl/umstr_axil_pkg.sv | 27 ++
 rtl/umstr_reg_if_axil_rd.sv | 115 +++++++++++
 rtl/umstr_reg_if_axil_wr.sv | 144 ++++++++++++++
 rtl/umstr_reg_if_axil.sv | 101 ++++++++++
 tb/tb_umstr_reg_if_axil.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umstr_axil_pkg.sv
// Shared definitions for the register-interface to AXI-Lite master bridge:
// response codes and the write/read channel state encodings.
package umstr_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_XFER = 2'd1,
        WR_RESP = 2'd2,
        WR_ACK  = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_RESP = 2'd2,
        RD_ACK  = 2'd3
    } rd_state_t;

    // Any response other than OKAY is reported to the requester as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/umstr_reg_if_axil_rd.sv
// Read channel: one register-interface read becomes one AR/R exchange.
// Read data is captured on the R handshake and held until the next read.
module umstr_reg_if_axil_rd
    import umstr_axil_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_wait,
    output logic                  reg_rd_ack,
    output logic                  reg_rd_err,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    rd_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  rready_reg, rready_next;
    logic                  wait_reg, wait_next;
    logic                  ack_reg, ack_next;
    logic                  err_reg, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RD_IDLE;
            araddr_reg  <= '0;
            rdata_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            wait_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            araddr_reg  <= araddr_next;
            rdata_reg   <= rdata_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            wait_reg    <= wait_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        araddr_next  = araddr_reg;
        rdata_next   = rdata_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        wait_next    = wait_reg;
        ack_next     = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            RD_IDLE: begin
                if (reg_rd_en) begin
                    araddr_next  = reg_rd_addr;
                    arvalid_next = 1'b1;
                    wait_next    = 1'b1;
                    state_next   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (m_axil_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axil_rvalid && rready_reg) begin
                    rready_next = 1'b0;
                    rdata_next  = m_axil_rdata;
                    err_next    = resp_is_err(m_axil_rresp);
                    ack_next    = 1'b1;
                    wait_next   = 1'b0;
                    state_next  = RD_ACK;
                end
            end
            RD_ACK: begin
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    assign m_axil_araddr  = araddr_reg;
    assign m_axil_arprot  = AXI_PROT;
    assign m_axil_arvalid = arvalid_reg;
    assign m_axil_rready  = rready_reg;
    assign reg_rd_data    = rdata_reg;
    assign reg_rd_wait    = wait_reg;
    assign reg_rd_ack     = ack_reg;
    assign reg_rd_err     = err_reg;

endmodule

// File: rtl/umstr_reg_if_axil_wr.sv
// Write channel: one register-interface write becomes one AW/W/B exchange.
// AW and W handshakes are tracked independently and may finish in any order.
module umstr_reg_if_axil_wr
    import umstr_axil_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    output logic                  reg_wr_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    wr_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;
    logic                  bready_reg, bready_next;
    logic                  wait_reg, wait_next;
    logic                  ack_reg, ack_next;
    logic                  err_reg, err_next;

    logic aw_done;
    logic w_done;

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done = !awvalid_reg || m_axil_awready;
    assign w_done  = !wvalid_reg  || m_axil_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= WR_IDLE;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            wait_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            awaddr_reg  <= awaddr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            wait_reg    <= wait_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        awaddr_next  = awaddr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        wait_next    = wait_reg;
        ack_next     = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            WR_IDLE: begin
                if (reg_wr_en) begin
                    awaddr_next  = reg_wr_addr;
                    wdata_next   = reg_wr_data;
                    wstrb_next   = reg_wr_strb;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                    wait_next    = 1'b1;
                    state_next   = WR_XFER;
                end
            end
            WR_XFER: begin
                if (awvalid_reg && m_axil_awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && m_axil_wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && bready_reg) begin
                    bready_next = 1'b0;
                    err_next    = resp_is_err(m_axil_bresp);
                    ack_next    = 1'b1;
                    wait_next   = 1'b0;
                    state_next  = WR_ACK;
                end
            end
            WR_ACK: begin
                state_next = WR_IDLE;
            end
            default: begin
                state_next = WR_IDLE;
            end
        endcase
    end

    assign m_axil_awaddr  = awaddr_reg;
    assign m_axil_awprot  = AXI_PROT;
    assign m_axil_awvalid = awvalid_reg;
    assign m_axil_wdata   = wdata_reg;
    assign m_axil_wstrb   = wstrb_reg;
    assign m_axil_wvalid  = wvalid_reg;
    assign m_axil_bready  = bready_reg;
    assign reg_wr_wait    = wait_reg;
    assign reg_wr_ack     = ack_reg;
    assign reg_wr_err     = err_reg;

endmodule

// File: rtl/umstr_reg_if_axil.sv
// Register-interface to AXI-Lite master bridge; the write and read channels
// are fully independent engines sharing only clock and reset.
module umstr_reg_if_axil
    import umstr_axil_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    output logic                  reg_wr_err,

    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_wait,
    output logic                  reg_rd_ack,
    output logic                  reg_rd_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    umstr_reg_if_axil_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .AXI_PROT   (AXI_PROT)
    ) u_wr (
        .clk            (clk),
        .rst            (rst),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_strb    (reg_wr_strb),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_wait    (reg_wr_wait),
        .reg_wr_ack     (reg_wr_ack),
        .reg_wr_err     (reg_wr_err),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    umstr_reg_if_axil_rd #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .AXI_PROT   (AXI_PROT)
    ) u_rd (
        .clk            (clk),
        .rst            (rst),
        .reg_rd_addr    (reg_rd_addr),
        .reg_rd_en      (reg_rd_en),
        .reg_rd_data    (reg_rd_data),
        .reg_rd_wait    (reg_rd_wait),
        .reg_rd_ack     (reg_rd_ack),
        .reg_rd_err     (reg_rd_err),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

endmodule

// File: tb/tb_umstr_reg_if_axil.sv
// Directed bench for umstr_reg_if_axil with a delay-programmable AXI-Lite slave.
module tb_umstr_reg_if_axil;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_wr_addr, reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_wait, reg_wr_ack, reg_wr_err;
    logic [31:0] reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_wait, reg_rd_ack, reg_rd_err;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready;
    logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // slave behaviour knobs
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = 32'h0;

    // handshake monitors
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, wr_ack_cnt = 0, rd_ack_cnt = 0, order_viol = 0;
    logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
    logic [3:0]  last_wstrb = 0;

    umstr_reg_if_axil dut (
        .clk(clk), .rst(rst),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
        .reg_wr_err(reg_wr_err),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack), .reg_rd_err(reg_rd_err),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (m_axil_awvalid && m_axil_awready) begin aw_cnt++; last_awaddr = m_axil_awaddr; end
            if (m_axil_wvalid && m_axil_wready) begin
                w_cnt++; last_wdata = m_axil_wdata; last_wstrb = m_axil_wstrb;
            end
            if (m_axil_arvalid && m_axil_arready) begin ar_cnt++; last_araddr = m_axil_araddr; end
            if (reg_wr_ack) wr_ack_cnt++;
            if (reg_rd_ack) rd_ack_cnt++;
            if ((m_axil_bready && (m_axil_awvalid || m_axil_wvalid)) ||
                (m_axil_rready && m_axil_arvalid)) order_viol++;
        end
    end

    // Slave channel responders: each waits for the master side, then a delay.
    initial begin
        m_axil_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axil_awvalid) begin
                repeat (aw_delay) @(negedge clk);
                m_axil_awready = 1'b1;
                @(negedge clk);
                m_axil_awready = 1'b0;
            end
        end
    end

    initial begin
        m_axil_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axil_wvalid) begin
                repeat (w_delay) @(negedge clk);
                m_axil_wready = 1'b1;
                @(negedge clk);
                m_axil_wready = 1'b0;
            end
        end
    end

    initial begin
        m_axil_bvalid = 1'b0;
        m_axil_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (m_axil_bready) begin
                repeat (b_delay) @(negedge clk);
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = bresp_val;
                @(negedge clk);
                m_axil_bvalid = 1'b0;
                m_axil_bresp  = 2'b00;
            end
        end
    end

    initial begin
        m_axil_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axil_arvalid) begin
                repeat (ar_delay) @(negedge clk);
                m_axil_arready = 1'b1;
                @(negedge clk);
                m_axil_arready = 1'b0;
            end
        end
    end

    initial begin
        m_axil_rvalid = 1'b0;
        m_axil_rresp  = 2'b00;
        m_axil_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (m_axil_rready) begin
                repeat (r_delay) @(negedge clk);
                m_axil_rvalid = 1'b1;
                m_axil_rresp  = rresp_val;
                m_axil_rdata  = rdata_val;
                @(negedge clk);
                m_axil_rvalid = 1'b0;
                m_axil_rresp  = 2'b00;
                m_axil_rdata  = 32'h0;
            end
        end
    end

    // Bounded waits; lat counts negedges from the request edge to the ack.
    task automatic wait_wr_ack(output int lat, output bit ok);
        ok = 1'b0; lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (reg_wr_ack) begin lat = i; ok = 1'b1; return; end
        end
    endtask

    task automatic wait_rd_ack(output int lat, output bit ok);
        ok = 1'b0; lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (reg_rd_ack) begin lat = i; ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reg_wr_en = 0; reg_rd_en = 0;
        reg_wr_addr = 0; reg_wr_data = 0; reg_wr_strb = 0; reg_rd_addr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready});
        end
        checks++;
        if ({reg_wr_wait, reg_wr_ack, reg_wr_err, reg_rd_wait, reg_rd_ack, reg_rd_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got %b want 000000",
                     {reg_wr_wait, reg_wr_ack, reg_wr_err, reg_rd_wait, reg_rd_ack, reg_rd_err});
        end
        checks++;
        if ({m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_araddr, reg_rd_data} !== 132'h0) begin
            errors++;
            $display("FAIL reset_payload: awaddr=%h wdata=%h wstrb=%h araddr=%h rd_data=%h want all 0",
                     m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_araddr, reg_rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_write_basic();
        int  base_aw, base_w, lat;
        bit  ok;
        logic [1:0] wait_seen;
        base_aw = aw_cnt; base_w = w_cnt;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_val = 2'b00;
        reg_wr_addr = 32'h10; reg_wr_data = 32'hDEADBEEF; reg_wr_strb = 4'hF; reg_wr_en = 1;
        @(negedge clk);
        checks++;
        if ({m_axil_awvalid, m_axil_wvalid} !== 2'b11) begin
            errors++; $display("FAIL wr_basic_valids_c1: got %b want 11", {m_axil_awvalid, m_axil_wvalid});
        end
        wait_seen[0] = reg_wr_wait;
        @(negedge clk);
        wait_seen[1] = reg_wr_wait;
        checks++;
        if (wait_seen !== 2'b11) begin
            errors++; $display("FAIL wr_basic_wait_c1_c2: got %b want 11", wait_seen);
        end
        checks++;
        if (m_axil_bready !== 1'b1) begin
            errors++; $display("FAIL wr_basic_bready_c2: got %b want 1", m_axil_bready);
        end
        @(negedge clk);
        reg_wr_en = 0;
        lat = reg_wr_ack ? 3 : -1;
        checks++;
        if (lat !== 3 || reg_wr_wait !== 1'b0 || reg_wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_basic_ack_c3: ack=%b wait=%b err=%b want ack=1 wait=0 err=0",
                     reg_wr_ack, reg_wr_wait, reg_wr_err);
        end
        checks++;
        if (last_awaddr !== 32'h10 || last_wdata !== 32'hDEADBEEF || last_wstrb !== 4'hF ||
            aw_cnt - base_aw != 1 || w_cnt - base_w != 1) begin
            errors++;
            $display("FAIL wr_basic_beats: addr=%h data=%h strb=%h aw=%0d w=%0d want 10/DEADBEEF/F/1/1",
                     last_awaddr, last_wdata, last_wstrb, aw_cnt - base_aw, w_cnt - base_w);
        end
        ok = 1'b1;
        @(negedge clk);
        checks++;
        if (reg_wr_ack !== 1'b0) begin
            errors++; $display("FAIL wr_basic_ack_pulse: ack=%b want 0 one cycle later", reg_wr_ack);
        end
        $display("test_write_basic done ok=%0b", ok);
    endtask

    task automatic test_write_split();
        int  base_aw, base_w, base_ack, lat;
        bit  ok;
        base_aw = aw_cnt; base_w = w_cnt; base_ack = wr_ack_cnt;
        aw_delay = 0; w_delay = 4; b_delay = 3; bresp_val = 2'b10;
        reg_wr_addr = 32'h24; reg_wr_data = 32'h0000A5A5; reg_wr_strb = 4'h3; reg_wr_en = 1;
        wait_wr_ack(lat, ok);
        reg_wr_en = 0;
        checks++;
        if (!ok || lat != 10) begin
            errors++; $display("FAIL wr_split_latency: got %0d want 10", lat);
        end
        checks++;
        if (reg_wr_err !== 1'b1) begin
            errors++; $display("FAIL wr_split_err: got %b want 1", reg_wr_err);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (aw_cnt - base_aw != 1 || w_cnt - base_w != 1 || wr_ack_cnt - base_ack != 1) begin
            errors++;
            $display("FAIL wr_split_counts: aw=%0d w=%0d ack=%0d want 1/1/1",
                     aw_cnt - base_aw, w_cnt - base_w, wr_ack_cnt - base_ack);
        end
        checks++;
        if (order_viol != 0) begin
            errors++; $display("FAIL wr_split_order: ready-before-accept events=%0d want 0", order_viol);
        end
        w_delay = 0; b_delay = 0; bresp_val = 2'b00;
        $display("test_write_split done lat=%0d", lat);
    endtask

    task automatic test_read();
        int  lat;
        bit  ok;
        ar_delay = 2; r_delay = 5; rresp_val = 2'b00; rdata_val = 32'h12345678;
        reg_rd_addr = 32'h40; reg_rd_en = 1;
        wait_rd_ack(lat, ok);
        reg_rd_en = 0;
        checks++;
        if (!ok || lat != 10) begin
            errors++; $display("FAIL rd_delayed_latency: got %0d want 10", lat);
        end
        checks++;
        if (reg_rd_data !== 32'h12345678 || reg_rd_err !== 1'b0 || last_araddr !== 32'h40) begin
            errors++;
            $display("FAIL rd_delayed_data: data=%h err=%b araddr=%h want 12345678/0/40",
                     reg_rd_data, reg_rd_err, last_araddr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (reg_rd_data !== 32'h12345678) begin
            errors++; $display("FAIL rd_data_hold: got %h want 12345678", reg_rd_data);
        end
        ar_delay = 0; r_delay = 0; rresp_val = 2'b10; rdata_val = 32'h0BAD0BAD;
        reg_rd_addr = 32'h44; reg_rd_en = 1;
        wait_rd_ack(lat, ok);
        reg_rd_en = 0;
        checks++;
        if (!ok || lat != 3 || reg_rd_err !== 1'b1 || reg_rd_data !== 32'h0BAD0BAD) begin
            errors++;
            $display("FAIL rd_slverr: lat=%0d err=%b data=%h want 3/1/0BAD0BAD", lat, reg_rd_err, reg_rd_data);
        end
        rresp_val = 2'b00;
        @(negedge clk);
        $display("test_read done");
    endtask

    task automatic test_back_to_back();
        int  base_aw, base_w, base_ack, base_rack;
        int  ack_cyc[3];
        int  rlat;
        bit  rok;
        bit  wok_all;
        base_aw = aw_cnt; base_w = w_cnt; base_ack = wr_ack_cnt; base_rack = rd_ack_cnt;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_val = 2'b00;
        ar_delay = 1; r_delay = 2; rdata_val = 32'hCAFEF00D;
        wok_all = 1'b1;
        fork
            begin
                int  lat;
                bit  ok;
                reg_wr_addr = 32'h100; reg_wr_data = 32'h11111111; reg_wr_strb = 4'hF; reg_wr_en = 1;
                for (int k = 0; k < 3; k++) begin
                    wait_wr_ack(lat, ok);
                    if (!ok) wok_all = 1'b0;
                    ack_cyc[k] = cyc;
                    if (k == 0) begin
                        reg_wr_addr = 32'h104; reg_wr_data = 32'h22222222; reg_wr_strb = 4'h0;
                    end else if (k == 1) begin
                        reg_wr_addr = 32'h108; reg_wr_data = 32'h33333333; reg_wr_strb = 4'h3;
                    end else begin
                        reg_wr_en = 0;
                    end
                end
            end
            begin
                reg_rd_addr = 32'h200; reg_rd_en = 1;
                wait_rd_ack(rlat, rok);
                reg_rd_en = 0;
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (!wok_all || aw_cnt - base_aw != 3 || w_cnt - base_w != 3 || wr_ack_cnt - base_ack != 3) begin
            errors++;
            $display("FAIL b2b_counts: ok=%b aw=%0d w=%0d ack=%0d want 1/3/3/3",
                     wok_all, aw_cnt - base_aw, w_cnt - base_w, wr_ack_cnt - base_ack);
        end
        checks++;
        if (ack_cyc[1] - ack_cyc[0] != 4 || ack_cyc[2] - ack_cyc[1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing: gaps %0d %0d want 4 4",
                     ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
        end
        checks++;
        if (last_awaddr !== 32'h108 || last_wdata !== 32'h33333333 || last_wstrb !== 4'h3) begin
            errors++;
            $display("FAIL b2b_last_beat: addr=%h data=%h strb=%h want 108/33333333/3",
                     last_awaddr, last_wdata, last_wstrb);
        end
        checks++;
        if (!rok || rlat != 6 || reg_rd_data !== 32'hCAFEF00D || rd_ack_cnt - base_rack != 1) begin
            errors++;
            $display("FAIL b2b_read: lat=%0d data=%h acks=%0d want 6/CAFEF00D/1",
                     rlat, reg_rd_data, rd_ack_cnt - base_rack);
        end
        ar_delay = 0; r_delay = 0;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        int  base_aw, lat;
        bit  ok;
        aw_delay = 20; w_delay = 20;
        reg_wr_addr = 32'h300; reg_wr_data = 32'h5A5A5A5A; reg_wr_strb = 4'hF; reg_wr_en = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_axil_awvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_precondition: awvalid=%b want 1", m_axil_awvalid);
        end
        rst = 1'b1; reg_wr_en = 0;
        @(negedge clk);
        checks++;
        if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready,
             reg_wr_wait, reg_wr_ack, reg_rd_wait, reg_rd_ack} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: got %b want 000000000",
                     {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready,
                      reg_wr_wait, reg_wr_ack, reg_rd_wait, reg_rd_ack});
        end
        rst = 1'b0;
        aw_delay = 0; w_delay = 0;
        repeat (25) @(negedge clk);
        base_aw = aw_cnt;
        reg_wr_addr = 32'h304; reg_wr_data = 32'h0F0F0F0F; reg_wr_strb = 4'hC; reg_wr_en = 1;
        wait_wr_ack(lat, ok);
        reg_wr_en = 0;
        checks++;
        if (!ok || lat != 3 || reg_wr_err !== 1'b0 || aw_cnt - base_aw != 1 ||
            last_awaddr !== 32'h304 || last_wdata !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL rstmid_recover: lat=%0d err=%b aw=%0d addr=%h data=%h want 3/0/1/304/0F0F0F0F",
                     lat, reg_wr_err, aw_cnt - base_aw, last_awaddr, last_wdata);
        end
        @(negedge clk);
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_split();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
